// File: rtl/seq_signed_or_unsigned_mul.sv
// rtl/seq_signed_or_unsigned_mul.sv - iterative radix-2 shift-add signed/unsigned multiplier
module seq_signed_or_unsigned_mul #(
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           up_valid,
    output logic           up_ready,
    input  logic [n-1:0]   a,
    input  logic [n-1:0]   b,
    input  logic           signed_mul,
    output logic           down_valid,
    input  logic           down_ready,
    output logic [2*n-1:0] res,
    output logic           busy
);

    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [2*n-1:0] mcand_q;
    logic [2*n-1:0] acc_q;
    logic [2*n-1:0] res_q;
    logic [n-1:0]   mplier_q;
    logic           neg_q;
    logic [CW-1:0]  cnt_q;
    logic           up_ready_q;
    logic           down_valid_q;
    logic           busy_q;

    logic [n-1:0]   mag_a_d;
    logic [n-1:0]   mag_b_d;
    logic [2*n-1:0] acc_d;
    logic [2*n-1:0] res_d;
    logic           last_iter;

    // The most-negative operand negates to itself, which read as unsigned is its magnitude.
    always_comb begin
        mag_a_d   = (signed_mul && a[n-1]) ? -a : a;
        mag_b_d   = (signed_mul && b[n-1]) ? -b : b;
        acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        res_d     = neg_q ? -acc_d : acc_d;
        last_iter = (cnt_q == CW'(n - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            mplier_q     <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
            up_ready_q   <= 1'b1;
            down_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (up_valid) begin
                        mcand_q    <= {{n{1'b0}}, mag_a_d};
                        mplier_q   <= mag_b_d;
                        acc_q      <= '0;
                        neg_q      <= signed_mul & (a[n-1] ^ b[n-1]);
                        cnt_q      <= '0;
                        up_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    if (last_iter) begin
                        cnt_q        <= '0;
                        res_q        <= res_d;
                        busy_q       <= 1'b0;
                        down_valid_q <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (down_ready) begin
                        down_valid_q <= 1'b0;
                        up_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    up_ready_q   <= 1'b1;
                    down_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign up_ready   = up_ready_q;
    assign down_valid = down_valid_q;
    assign res        = res_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// tb/tb_seq_signed_or_unsigned_mul.sv - scoreboard bench for seq_signed_or_unsigned_mul (n=4,8,16)
module tb_seq_signed_or_unsigned_mul;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        uv8, ur8, sm8, dv8, dr8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        uv4, ur4, sm4, dv4, dr4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  res4;
    logic        uv16, ur16, sm16, dv16, dr16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q8[$];
    logic [31:0] q4[$];
    logic [31:0] q16[$];

    seq_signed_or_unsigned_mul #(.n(8)) u8 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv8), .up_ready(ur8), .a(a8), .b(b8),
        .signed_mul(sm8), .down_valid(dv8), .down_ready(dr8), .res(res8), .busy(busy8)
    );
    seq_signed_or_unsigned_mul #(.n(4)) u4 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv4), .up_ready(ur4), .a(a4), .b(b4),
        .signed_mul(sm4), .down_valid(dv4), .down_ready(dr4), .res(res4), .busy(busy4)
    );
    seq_signed_or_unsigned_mul #(.n(16)) u16 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv16), .up_ready(ur16), .a(a16), .b(b16),
        .signed_mul(sm16), .down_valid(dv16), .down_ready(dr16), .res(res16), .busy(busy16)
    );

    // Golden product: plain integer multiply of the (sign-extended) operands, truncated to 2w bits.
    function automatic logic [31:0] gold(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp);
        int guard = 0;
        while (!ur8 && guard < 50) begin @(negedge clk); guard++; end
        n_checks++;
        if (ur8 !== 1'b1) begin
            n_fail++;
            $display("FAIL send8_ready: up_ready=%0b required 1", ur8);
        end
        a8 = a; b8 = b; sm8 = s; uv8 = 1'b1;
        q8.push_back({16'h0, exp});
        @(negedge clk);
        uv8 = 1'b0;
    endtask

    task automatic wait_dv8(output int lat);
        lat = 0;
        while (!dv8 && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic pop8(input string name);
        logic [31:0] exp;
        n_checks++;
        if (q8.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, res=%h", name, res8);
        end else begin
            exp = q8.pop_front();
            if (dv8 !== 1'b1 || res8 !== exp[15:0]) begin
                n_fail++;
                $display("FAIL %s: down_valid=%0b res=%h required down_valid=1 res=%h",
                         name, dv8, res8, exp[15:0]);
            end
        end
        dr8 = 1'b1;
        @(negedge clk);
        dr8 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dv8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: dv=%0b busy=%0b res=%h required 0 0 0000", dv8, busy8, res8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ur8 !== 1'b1 || ur4 !== 1'b1 || ur16 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: up_ready=%0b/%0b/%0b required 1/1/1", ur8, ur4, ur16);
        end
    endtask

    task automatic test_unsigned_max();
        int lat;
        send8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        n_checks++;
        if (busy8 !== 1'b1 || ur8 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_accept: busy=%0b up_ready=%0b required 1 0", busy8, ur8);
        end
        wait_dv8(lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL latency_ff: cycles=%0d required 8", lat);
        end
        pop8("unsigned_ff_ff");
    endtask

    task automatic test_signed_corners();
        logic [7:0]  ta[5] = '{8'h80, 8'h80, 8'h00, 8'h7F, 8'hFF};
        logic [7:0]  tb[5] = '{8'h80, 8'h01, 8'h80, 8'h80, 8'hFF};
        logic [15:0] te[5] = '{16'h4000, 16'hFF80, 16'h0000, 16'hC080, 16'h0001};
        int lat;
        for (int i = 0; i < 5; i++) begin
            send8(ta[i], tb[i], 1'b1, te[i]);
            wait_dv8(lat);
            n_checks++;
            if (lat !== 8) begin
                n_fail++;
                $display("FAIL latency_signed_%0d: cycles=%0d required 8", i, lat);
            end
            pop8("signed_corner");
        end
    endtask

    task automatic test_mode_select();
        int lat;
        send8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        wait_dv8(lat);
        pop8("signed_fd_05");
        send8(8'hFD, 8'h05, 1'b0, 16'h04F1);
        wait_dv8(lat);
        pop8("unsigned_fd_05");
    endtask

    task automatic test_backpressure();
        int lat;
        send8(8'h12, 8'h34, 1'b0, 16'h03A8);
        wait_dv8(lat);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (dv8 !== 1'b1 || ur8 !== 1'b0 || res8 !== q8[0][15:0]) begin
                n_fail++;
                $display("FAIL stall_%0d: dv=%0b ur=%0b res=%h required 1 0 %h",
                         i, dv8, ur8, res8, q8[0][15:0]);
            end
            @(negedge clk);
        end
        pop8("stall_release");
        n_checks++;
        if (ur8 !== 1'b1 || dv8 !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release: ur=%0b dv=%0b required 1 0", ur8, dv8);
        end
    endtask

    task automatic test_operand_hold();
        int lat;
        send8(8'hF3, 8'h06, 1'b1, 16'hFFB2);
        for (int i = 0; i < 5; i++) begin
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            sm8 = 1'($urandom);
            uv8 = (i >= 1 && i <= 3);
            @(negedge clk);
        end
        uv8 = 1'b0;
        wait_dv8(lat);
        n_checks++;
        if (lat + 5 !== 8) begin
            n_fail++;
            $display("FAIL latency_hold: cycles=%0d required 8", lat + 5);
        end
        pop8("operand_hold");
        repeat (3) @(negedge clk);
        n_checks++;
        if (dv8 !== 1'b0 || busy8 !== 1'b0 || ur8 !== 1'b1) begin
            n_fail++;
            $display("FAIL no_extra_accept: dv=%0b busy=%0b ur=%0b required 0 0 1", dv8, busy8, ur8);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        send8(8'h55, 8'h33, 1'b0, 16'h10EF);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dv8 !== 1'b0 || busy8 !== 1'b0 || res8 !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset: dv=%0b busy=%0b res=%h required 0 0 0000", dv8, busy8, res8);
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ur8 !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: up_ready=%0b required 1", ur8);
        end
        send8(8'h07, 8'h09, 1'b0, 16'h003F);
        wait_dv8(lat);
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL latency_post_reset: cycles=%0d required 8", lat);
        end
        pop8("post_reset_07_09");
    endtask

    task automatic test_sweep4();
        logic [31:0] exp;
        int lat, guard;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    guard = 0;
                    while (!ur4 && guard < 50) begin @(negedge clk); guard++; end
                    a4 = 4'(i); b4 = 4'(j); sm4 = 1'(s); uv4 = 1'b1;
                    q4.push_back(gold(4, 16'(i), 16'(j), 1'(s)));
                    @(negedge clk);
                    uv4 = 1'b0;
                    lat = 0;
                    while (!dv4 && lat < 100) begin @(negedge clk); lat++; end
                    exp = q4.pop_front();
                    n_checks++;
                    if (dv4 !== 1'b1 || res4 !== exp[7:0] || lat !== 4) begin
                        n_fail++;
                        $display("FAIL sweep4 a=%h b=%h s=%0d: res=%h lat=%0d required %h lat=4",
                                 a4, b4, s, res4, lat, exp[7:0]);
                    end
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    dr4 = 1'b1;
                    @(negedge clk);
                    dr4 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_sweep16();
        logic [31:0] exp;
        logic [15:0] ra, rb;
        logic        rs;
        int lat, guard;
        for (int k = 0; k < 200; k++) begin
            ra = (k == 0) ? 16'h8000 : 16'($urandom);
            rb = (k == 0) ? 16'h8000 : (k == 1) ? 16'h0000 : 16'($urandom);
            rs = (k < 2) ? 1'b1 : 1'(k);
            guard = 0;
            while (!ur16 && guard < 50) begin @(negedge clk); guard++; end
            a16 = ra; b16 = rb; sm16 = rs; uv16 = 1'b1;
            q16.push_back(gold(16, ra, rb, rs));
            @(negedge clk);
            uv16 = 1'b0;
            lat = 0;
            while (!dv16 && lat < 100) begin @(negedge clk); lat++; end
            exp = q16.pop_front();
            n_checks++;
            if (dv16 !== 1'b1 || res16 !== exp || lat !== 16) begin
                n_fail++;
                $display("FAIL sweep16 a=%h b=%h s=%0b: res=%h lat=%0d required %h lat=16",
                         ra, rb, rs, res16, lat, exp);
            end
            dr16 = 1'b1;
            @(negedge clk);
            dr16 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {uv8, sm8, dr8, uv4, sm4, dr4, uv16, sm16, dr16} = '0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_mode_select();
        test_backpressure();
        test_operand_hold();
        test_reset_mid();
        test_sweep4();
        test_sweep16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
